// File: rtl/frame_config_ctrl.sv
// rtl/frame_config_ctrl.sv - configuration frame sequencer: header decode, row load, one-hot column strobe
// Optional FRAME_CHECKSUM_EN adds a CHECK state that verifies an XOR checksum word before strobing.
`timescale 1ns/1ps
module frame_config_ctrl #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 4,
    parameter int NumCols         = 4
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic [FrameBitsPerRow-1:0]           cfg_data,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic                                 cfg_abort,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                 busy,
    output logic                                 err,
    output logic [15:0]                          frame_cnt
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int STB_W = NumCols * MaxFramesPerCol;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumRows - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        SETUP,
        STROBE,
        GAP
`ifdef FRAME_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    state_t state, next_state;

    logic [7:0]       col_q;
    logic [7:0]       frm_q;
    logic [ROW_W-1:0] row_cnt;
    logic             hs;
    logic             hdr_ok;
    logic [31:0]      hdr_col;
    logic [31:0]      hdr_frm;
    logic [31:0]      strobe_idx;
    logic [STB_W-1:0] strobe_onehot;
    logic             load_hdr;
    logic             wr_row;
    logic             fire;
    logic             err_next;
`ifdef FRAME_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] csum;
`endif

    // Handshake qualifiers come only from the registered state.
    assign cfg_ready = (state == IDLE) || (state == DATA)
`ifdef FRAME_CHECKSUM_EN
                       || (state == CHECK)
`endif
                       ;
    assign busy = (state != IDLE);
    assign hs   = cfg_valid & cfg_ready;

    assign hdr_col = {24'd0, cfg_data[23:16]};
    assign hdr_frm = {24'd0, cfg_data[15:8]};
    assign hdr_ok  = (cfg_data[31:24] == 8'hA5) &&
                     (hdr_col < 32'(NumCols)) &&
                     (hdr_frm < 32'(MaxFramesPerCol));

    assign strobe_idx = {24'd0, col_q} * 32'(MaxFramesPerCol) + {24'd0, frm_q};

    always_comb begin
        strobe_onehot = '0;
        for (int i = 0; i < STB_W; i++) begin
            strobe_onehot[i] = (strobe_idx == 32'(i));
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort takes priority over any handshake in the abortable states.
    always_comb begin
        next_state = state;
        load_hdr   = 1'b0;
        wr_row     = 1'b0;
        fire       = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (!cfg_abort && hs) begin
                    if (hdr_ok) begin
                        load_hdr   = 1'b1;
                        next_state = DATA;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cfg_abort) begin
                    next_state = IDLE;
                end else if (hs) begin
                    wr_row = 1'b1;
                    if (row_cnt == LAST_ROW) begin
`ifdef FRAME_CHECKSUM_EN
                        next_state = CHECK;
`else
                        next_state = SETUP;
`endif
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CHECK: begin
                if (cfg_abort) begin
                    next_state = IDLE;
                end else if (hs) begin
                    if (cfg_data == csum) begin
                        next_state = SETUP;
                    end else begin
                        err_next   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
`endif
            SETUP: begin
                if (cfg_abort) begin
                    next_state = IDLE;
                end else begin
                    fire       = 1'b1;
                    next_state = STROBE;
                end
            end
            STROBE:  next_state = GAP;
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            FrameData   <= '0;
            FrameStrobe <= '0;
            err         <= 1'b0;
            frame_cnt   <= 16'd0;
            col_q       <= 8'd0;
            frm_q       <= 8'd0;
            row_cnt     <= '0;
        end else begin
            err         <= err_next;
            FrameStrobe <= fire ? strobe_onehot : '0;
            if (fire) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (load_hdr) begin
                col_q   <= cfg_data[23:16];
                frm_q   <= cfg_data[15:8];
                row_cnt <= '0;
            end
            if (wr_row) begin
                FrameData[row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data;
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Running XOR restarts with the first data word of each frame.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            csum <= '0;
        end else if (wr_row) begin
            csum <= (row_cnt == '0) ? cfg_data : (csum ^ cfg_data);
        end
    end
`endif

endmodule

// File: tb/tb_frame_config_ctrl.sv
// tb/tb_frame_config_ctrl.sv - randomized self-checking bench for frame_config_ctrl
`timescale 1ns/1ps
module tb_frame_config_ctrl;
    localparam int FBR  = 32;
    localparam int MFPC = 20;
    localparam int NR   = 4;
    localparam int NC   = 4;
`ifdef FRAME_CHECKSUM_EN
    localparam bit HAS_CS = 1'b1;
`else
    localparam bit HAS_CS = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              resetn = 1'b0;
    logic [FBR-1:0]    cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_abort = 1'b0;
    logic              cfg_ready;
    logic [NR*FBR-1:0] FrameData;
    logic [NC*MFPC-1:0] FrameStrobe;
    logic              busy;
    logic              err;
    logic [15:0]       frame_cnt;

    frame_config_ctrl #(
        .FrameBitsPerRow(FBR), .MaxFramesPerCol(MFPC), .NumRows(NR), .NumCols(NC)
    ) dut (
        .CLK(CLK), .resetn(resetn), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_abort(cfg_abort), .FrameData(FrameData),
        .FrameStrobe(FrameStrobe), .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: rows last written, committed frame count
    logic [FBR-1:0] mrow [NR];
    logic [15:0]    mcnt = 16'd0;

    function automatic logic [NR*FBR-1:0] model_data();
        logic [NR*FBR-1:0] d;
        for (int r = 0; r < NR; r++) d[r*FBR +: FBR] = mrow[r];
        return d;
    endfunction

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int strobe_events = 0;
    int err_events = 0;
    int strobe_cyc = 0;
    logic [NC*MFPC-1:0] seen_strobe = '0;

    always @(negedge CLK) begin
        if (resetn) begin
            if (FrameStrobe != '0) begin
                strobe_events++;
                strobe_cyc  = cyc;
                seen_strobe = FrameStrobe;
                check("data_at_strobe", FrameData, model_data());
            end
            if (err) err_events++;
        end
    end

    function automatic int gapn(input bit jit);
        return jit ? int'($urandom_range(0, 3)) : 0;
    endfunction

    // Present one word and hold it until accepted; returns the handshake cycle.
    task automatic push(input logic [31:0] w, input int gap, output int hs_cyc);
        int  n;
        logic rdy;
        n = 0;
        cfg_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        forever begin
            @(negedge CLK);
            rdy = cfg_ready;
            @(posedge CLK);
            n++;
            if (rdy) break;
            if (n > 100) begin
                check("handshake_timeout", 128'(0), 128'(1));
                break;
            end
        end
        #1;
        hs_cyc    = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic load_frame(input int col, input int fr, input logic [NR*FBR-1:0] rows,
                              input bit jit, input bit bad_cs, output int k);
        logic [31:0] cs;
        cs = '0;
        push({8'hA5, 8'(col), 8'(fr), 8'($urandom)}, gapn(jit), k);
        for (int r = 0; r < NR; r++) begin
            push(rows[r*FBR +: FBR], gapn(jit), k);
            mrow[r] = rows[r*FBR +: FBR];
            cs ^= rows[r*FBR +: FBR];
        end
        if (HAS_CS) push(bad_cs ? (cs ^ 32'h1) : cs, gapn(jit), k);
    endtask

    task automatic send_frame(input int col, input int fr, input logic [NR*FBR-1:0] rows,
                              input bit jit, input bit bad_cs);
        int k, s0, e0;
        bit good;
        logic [NC*MFPC-1:0] exp_s;
        s0 = strobe_events;
        e0 = err_events;
        good = !(HAS_CS && bad_cs);
        load_frame(col, fr, rows, jit, bad_cs, k);
        repeat (6) @(posedge CLK);
        #1;
        if (good) begin
            exp_s = '0;
            exp_s[col*MFPC + fr] = 1'b1;
            mcnt = mcnt + 16'd1;
            check("strobe_count", 128'(strobe_events - s0), 128'(1));
            check("strobe_onehot", 128'(seen_strobe), 128'(exp_s));
            check("strobe_latency", 128'(strobe_cyc - k), 128'(1));
            check("err_none", 128'(err_events - e0), 128'(0));
        end else begin
            check("strobe_rejected", 128'(strobe_events - s0), 128'(0));
            check("err_checksum", 128'(err_events - e0), 128'(1));
        end
        check("frame_cnt", 128'(frame_cnt), 128'(mcnt));
        check("idle_after", 128'({busy, cfg_ready}), 128'(2'b01));
    endtask

    task automatic bad_header(input logic [31:0] w);
        int k, s0;
        s0 = strobe_events;
        push(w, 0, k);
        @(negedge CLK);
        check("err_pulse", 128'(err), 128'(1));
        check("ready_after_bad", 128'({cfg_ready, busy}), 128'(2'b10));
        @(negedge CLK);
        check("err_one_cycle", 128'(err), 128'(0));
        repeat (3) @(negedge CLK);
        check("no_strobe_bad", 128'(strobe_events - s0), 128'(0));
        check("frame_cnt_bad", 128'(frame_cnt), 128'(mcnt));
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_bad_header();
        case ($urandom_range(0, 2))
            0:       return {8'hA5 ^ 8'($urandom_range(1, 255)), 24'($urandom)};
            1:       return {8'hA5, 8'($urandom_range(NC, 255)), 8'($urandom_range(0, MFPC-1)), 8'($urandom)};
            default: return {8'hA5, 8'($urandom_range(0, NC-1)), 8'($urandom_range(MFPC, 255)), 8'($urandom)};
        endcase
    endfunction

    initial begin
        #600000;
        check("watchdog", 128'(0), 128'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int k, s0, e0, n;
        logic [NR*FBR-1:0] rows;
        for (int r = 0; r < NR; r++) mrow[r] = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", 128'(cfg_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_data", 128'(FrameData), 128'(0));
        check("rst_strobe", 128'(FrameStrobe), 128'(0));
        check("rst_cnt_err", 128'({frame_cnt, err}), 128'(0));
        resetn = 1'b1;
        @(posedge CLK);
        #1;

        // Directed frame: column 1 frame 3 -> strobe bit 23
        send_frame(1, 3, 128'h44444444_33333333_22222222_11111111, 1'b0, 1'b0);
        check("directed_data", 128'(FrameData), 128'h44444444_33333333_22222222_11111111);
        check("directed_bit23", 128'(seen_strobe[23]), 128'(1));
        check("directed_cnt", 128'(frame_cnt), 128'(1));

        bad_header(32'h5A000000);
        bad_header(32'hA5040000);
        bad_header(32'hA5001400);

`ifdef FRAME_CHECKSUM_EN
        send_frame(2, 5, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        send_frame(3, 7, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 4) == 0) bad_header(rand_bad_header());
            rows = {$urandom, $urandom, $urandom, $urandom};
            send_frame(int'($urandom_range(0, NC-1)), int'($urandom_range(0, MFPC-1)), rows,
                       1'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Reset asserted while the strobe is high
        load_frame(2, 11, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, k);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (FrameStrobe != '0) break;
            if (n > 12) begin
                check("strobe_wait_timeout", 128'(0), 128'(1));
                break;
            end
        end
        #1;
        resetn = 1'b0;
        #1;
        check("rst_mid_strobe", 128'(FrameStrobe), 128'(0));
        check("rst_mid_data", 128'(FrameData), 128'(0));
        check("rst_mid_cnt_busy", 128'({frame_cnt, busy}), 128'(0));
        for (int r = 0; r < NR; r++) mrow[r] = '0;
        mcnt = 16'd0;
        @(posedge CLK);
        #1;
        resetn = 1'b1;
        @(posedge CLK);
        #1;

        // Abort after two rows, with a word offered on the abort cycle
        s0 = strobe_events;
        e0 = err_events;
        push({8'hA5, 8'd3, 8'd2, 8'd0}, 0, k);
        for (int r = 0; r < 2; r++) begin
            mrow[r] = $urandom;
            push(mrow[r], 0, k);
        end
        cfg_data  = $urandom;
        cfg_valid = 1'b1;
        cfg_abort = 1'b1;
        @(posedge CLK);
        #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        check("abort_idle", 128'(busy), 128'(0));
        check("abort_rows_kept", 128'(FrameData), 128'(model_data()));
        repeat (5) @(posedge CLK);
        #1;
        check("abort_no_strobe", 128'(strobe_events - s0), 128'(0));
        check("abort_no_err", 128'(err_events - e0), 128'(0));
        send_frame(0, 19, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        check("abort_then_bit19", 128'(seen_strobe), 128'(1) << 19);
        check("abort_then_cnt", 128'(frame_cnt), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_config_ctrl.md
# frame_config_ctrl

Configuration frame sequencer for the fabric's bitstream path. Accepts a 32-bit word stream over a valid/ready handshake, decodes a frame header, loads one word per fabric row into the FrameData bus and fires a single-cycle one-hot pulse on the addressed column's FrameStrobe bit. It sits between the bitstream source (UART/SPI loader or host port) and the FrameData/FrameStrobe daisy-chain inputs at the fabric edge.

## Interface
Parameters:
- FrameBitsPerRow, 32, config bits per tile row; equals the stream word width.
- MaxFramesPerCol, 20, frames per column; width of one column's strobe slice.
- NumRows, 4, fabric rows; data words per frame.
- NumCols, 4, fabric columns.

Ports:
- CLK  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cfg_data  in  FrameBitsPerRow  stream word.
- cfg_valid  in  1  word present.
- cfg_ready  out  1  controller accepts word; transfer on cfg_valid & cfg_ready.
- cfg_abort  in  1  discard the partially received frame.
- FrameData  out  NumRows*FrameBitsPerRow  row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  out  NumCols*MaxFramesPerCol  column c occupies bits [c*MaxFramesPerCol +: MaxFramesPerCol].
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on a rejected header or frame.
- frame_cnt  out  16  committed frames; wraps 0xFFFF -> 0x0000.

## Operation
- States: IDLE, DATA, SETUP, STROBE, GAP (plus CHECK when checksum enabled).
- Header word: [31:24] = 8'hA5 magic, [23:16] column, [15:8] frame index, [7:0] ignored.
- IDLE: cfg_ready=1. Header accepted; if magic wrong, column >= NumCols or frame >= MaxFramesPerCol -> err pulse, stay IDLE. Otherwise latch column/frame, clear row counter, go DATA.
- DATA: cfg_ready=1. Each accepted word writes FrameData row = row counter (row 0 first), counter increments. After row NumRows-1 -> SETUP (or CHECK).
- SETUP: cfg_ready=0, FrameData stable, strobe low; next cycle -> STROBE.
- STROBE: exactly one FrameStrobe bit high, index column*MaxFramesPerCol + frame; frame_cnt increments; -> GAP.
- GAP: strobe low, FrameData held; -> IDLE.
- FrameData changes only on DATA-state handshakes; never while any strobe bit is high.
- cfg_valid low in DATA: wait indefinitely, no timeout.
- cfg_abort in IDLE/DATA/SETUP/CHECK: -> IDLE next edge, no strobe, no err, FrameData keeps written rows. Ignored in STROBE/GAP. Abort wins over a simultaneous handshake (word discarded).
- Reset (any time, including mid-frame or mid-strobe): state IDLE, FrameData=0, FrameStrobe=0, err=0, frame_cnt=0, busy=0, cfg_ready=1 after release.

## Timing
- Last data word handshake at edge k: SETUP after k, FrameStrobe high for the cycle after k+1, low after k+2, IDLE and cfg_ready=1 after k+3.
- Minimum frame period: 1 header + NumRows data + 3 overhead cycles (NumRows+4 total at full throughput).
- err asserted for the cycle following the offending handshake.
- All outputs are registered; no combinational input-to-output path except none (cfg_ready is decoded from registered state).

## Configuration
- FRAME_CHECKSUM_EN defined: after the last data word, state CHECK (cfg_ready=1) accepts one extra word that must equal XOR of all NumRows data words. Match -> SETUP; mismatch -> err pulse, IDLE, no strobe, frame_cnt unchanged. Timing reference edge k becomes the checksum handshake.
- Not defined: CHECK state absent; DATA goes straight to SETUP.

## Test plan
- Header 0xA5010300, rows 0x11111111..0x44444444 (NumRows=4) -> FrameData = {0x44444444,0x33333333,0x22222222,0x11111111}, FrameStrobe bit 23 high for exactly one cycle 2 cycles after last word, frame_cnt=1.
- Header 0x5A000000 and header 0xA5040000 (col 4) -> err pulses, no strobe, cfg_ready stays 1.
- cfg_valid toggled randomly during DATA -> same FrameData/strobe result as back-to-back stream; FrameData never changes while strobe high.
- cfg_abort after 2 data words, then valid frame col 0 frame 19 -> only bit 19 strobes, frame_cnt=1.
- resetn low during STROBE -> FrameStrobe and FrameData 0 immediately, frame_cnt 0, busy 0.
- FRAME_CHECKSUM_EN: correct XOR word -> strobe; checksum off by one bit -> err pulse, no strobe, frame_cnt unchanged.
